// File: rtl/seg_display_ctrl_pkg.sv
// Shared constants for the memory-mapped seven-segment display controller:
// register map, CTRL bit positions and the hex font.
package seg_display_ctrl_pkg;

  localparam logic [1:0] SEG_ADDR_DATA = 2'd0;
  localparam logic [1:0] SEG_ADDR_DP   = 2'd1;
  localparam logic [1:0] SEG_ADDR_EN   = 2'd2;
  localparam logic [1:0] SEG_ADDR_CTRL = 2'd3;

  localparam int unsigned CTRL_ZERO_SUPPRESS = 0;
  localparam int unsigned CTRL_BLINK_EN      = 1;

  // Active-high g..a patterns; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex-nibble to seven-segment (g..a, active-high) decoder.
module seg_hex_font
  import seg_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller with register readback,
// per-digit enable, decimal points, leading-zero suppression and blink.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [1:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] dig_en
);

  localparam int unsigned DataW = 4 * DIGITS;
  localparam int unsigned DivW  = $clog2(SCAN_DIV);
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FrmW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);

  localparam logic [7:0]        SegInactive = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DigInactive = {DIGITS{DIG_ACTIVE_LOW}};

  logic [DataW-1:0]  data_q;
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] en_q;
  logic              zero_sup_q;
  logic              blink_en_q;

  logic [DivW-1:0]   div_q;
  logic [IdxW-1:0]   idx_q;
  logic [FrmW-1:0]   frame_q;
  logic              blink_phase_q;

  logic [31:0]       rdata_q;
  logic [31:0]       rd_val;
  logic [7:0]        seg_q;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] dig_q;
  logic [DIGITS-1:0] dig_d;

  logic              div_tc;
  logic              idx_wrap;
  logic              frame_tick;
  logic [3:0]        cur_nibble;
  logic [6:0]        font_segs;
  logic [DIGITS-1:0] upper_zero;
  logic              zero_acc;
  logic              blank;
  logic              suppress;

  if (DataW < 32) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:DataW];
  end

  // Register file; a read in the same cycle sees the pre-write value.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      data_q     <= '0;
      dp_q       <= '0;
      en_q       <= '1;
      zero_sup_q <= 1'b0;
      blink_en_q <= 1'b0;
    end else if (cs && wr_en) begin
      case (addr)
        SEG_ADDR_DATA: data_q <= wdata[DataW-1:0];
        SEG_ADDR_DP:   dp_q   <= wdata[DIGITS-1:0];
        SEG_ADDR_EN:   en_q   <= wdata[DIGITS-1:0];
        SEG_ADDR_CTRL: begin
          zero_sup_q <= wdata[CTRL_ZERO_SUPPRESS];
          blink_en_q <= wdata[CTRL_BLINK_EN];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      SEG_ADDR_DATA: rd_val[DataW-1:0]  = data_q;
      SEG_ADDR_DP:   rd_val[DIGITS-1:0] = dp_q;
      SEG_ADDR_EN:   rd_val[DIGITS-1:0] = en_q;
      SEG_ADDR_CTRL: begin
        rd_val[CTRL_ZERO_SUPPRESS] = zero_sup_q;
        rd_val[CTRL_BLINK_EN]      = blink_en_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= (cs && rd_en) ? rd_val : '0;
    end
  end

  assign div_tc     = (div_q == DivLast);
  assign idx_wrap   = (idx_q == IdxLast);
  assign frame_tick = div_tc && idx_wrap;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      div_q <= div_tc ? '0 : div_q + 1'b1;
      if (div_tc) begin
        idx_q <= idx_wrap ? '0 : idx_q + 1'b1;
      end
      if (frame_tick) begin
        if (frame_q == FrmLast) begin
          frame_q       <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

  // upper_zero[k] is set when nibble k and every nibble above it are zero.
  always_comb begin
    upper_zero = '0;
    zero_acc   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc && (data_q[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_acc;
    end
  end

  assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];

  seg_hex_font u_font (
    .nibble (cur_nibble),
    .segs   (font_segs)
  );

  assign blank    = !en_q[idx_q] || (blink_en_q && blink_phase_q);
  assign suppress = zero_sup_q && (idx_q != '0) && upper_zero[idx_q];

  // A suppressed digit keeps its slot only to show a set decimal point.
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (!blank) begin
      if (!suppress) begin
        seg_d        = {dp_q[idx_q], font_segs};
        dig_d[idx_q] = 1'b1;
      end else if (dp_q[idx_q]) begin
        seg_d        = 8'h80;
        dig_d[idx_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      seg_q <= SegInactive;
      dig_q <= DigInactive;
    end else begin
      seg_q <= seg_d ^ SegInactive;
      dig_q <= dig_d ^ DigInactive;
    end
  end

  assign rdata   = rdata_q;
  assign seg_out = seg_q;
  assign dig_en  = dig_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: cycle-count based reference model
// plus directed vectors with hand-computed expectations.
module tb_seg_display_ctrl;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        cs    = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  seg_out;
  logic [D-1:0] dig_en;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seg_display_ctrl #(
    .DIGITS         (D),
    .SCAN_DIV       (SD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .cs      (cs),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .seg_out (seg_out),
    .dig_en  (dig_en)
  );

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model state: m_* current registers, s_* registers as seen before the last edge,
  // n = clock edges since reset release.
  logic [15:0] m_data, s_data;
  logic [3:0]  m_dp, s_dp, m_en, s_en;
  logic [1:0]  m_ctrl, s_ctrl;
  logic [31:0] m_rdata;
  int          n;

  function automatic logic [31:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_data};
      2'd1:    return {28'h0, m_dp};
      2'd2:    return {28'h0, m_en};
      default: return {30'h0, m_ctrl};
    endcase
  endfunction

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_data = '0; m_dp = '0; m_en = 4'hF; m_ctrl = '0;
      s_data = '0; s_dp = '0; s_en = 4'hF; s_ctrl = '0;
      m_rdata = '0;
      n = 0;
    end else begin
      s_data = m_data; s_dp = m_dp; s_en = m_en; s_ctrl = m_ctrl;
      m_rdata = (cs && rd_en) ? reg_val(addr) : 32'h0;
      if (cs && wr_en) begin
        case (addr)
          2'd0:    m_data = wdata[15:0];
          2'd1:    m_dp   = wdata[3:0];
          2'd2:    m_en   = wdata[3:0];
          default: m_ctrl = wdata[1:0];
        endcase
      end
      n++;
    end
  end

  task automatic expect_out(output logic [7:0] es, output logic [3:0] ed);
    int t, k;
    bit phase, blank, sup;
    logic [3:0] nib;
    es = '0;
    ed = '0;
    if (n == 0) return;
    t     = n - 1;
    k     = (t / SD) % D;
    phase = ((t / (SD * D * BF)) % 2) == 1;
    nib   = s_data[4*k +: 4];
    blank = !s_en[k] || (s_ctrl[1] && phase);
    sup   = s_ctrl[0] && (k > 0) && ((s_data >> (4 * k)) == '0);
    if (!blank) begin
      if (!sup) begin
        es = {s_dp[k], FONT[nib]};
        ed = 4'(1 << k);
      end else if (s_dp[k]) begin
        es = 8'h80;
        ed = 4'(1 << k);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [7:0] es;
    logic [3:0] ed;
    expect_out(es, ed);
    chk("model_seg", 32'(seg_out), 32'(es));
    chk("model_dig", 32'(dig_en), 32'(ed));
    chk("model_rdata", rdata, m_rdata);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cmp_model();
  endtask

  task automatic access(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; rd_en = r; wr_en = w; addr = a; wdata = d;
    tick();
    cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Advance until the outputs show digit k.
  task automatic goto_digit(input int k);
    int guard;
    guard = 0;
    tick();
    while (((n - 1) / SD) % D != k) begin
      tick();
      guard++;
      if (guard > 64) begin
        chk("goto_timeout", 32'h1, 32'h0);
        return;
      end
    end
  endtask

  logic [7:0] t2_seg [4] = '{8'h06, 8'h39, 8'h6D, 8'h77};
  logic [3:0] t1_dig [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int bad, dark, lit, guard;

    // 1: reset state, then scan order with a 4-cycle dwell
    @(negedge clock);
    chk("reset_seg", 32'(seg_out), 32'h0);
    chk("reset_dig", 32'(dig_en), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("t1_first_seg", 32'(seg_out), 32'h3F);
    chk("t1_first_dig", 32'(dig_en), 32'h1);
    for (int s = 0; s < 4; s++) begin
      repeat (4) tick();
      chk("t1_step_dig", 32'(dig_en), 32'(t1_dig[s]));
    end

    // 2: data pattern and readback, including read-during-write
    access(1'b0, 1'b1, 2'd0, 32'h0000_A5C1);
    for (int k = 0; k < 4; k++) begin
      goto_digit(k);
      chk("t2_seg", 32'(seg_out), 32'(t2_seg[k]));
      chk("t2_dig", 32'(dig_en), 32'(1 << k));
    end
    access(1'b1, 1'b0, 2'd0, 32'h0);
    chk("t2_read_data", rdata, 32'h0000_A5C1);
    access(1'b1, 1'b1, 2'd0, 32'h0000_1234);
    chk("t2_rw_old", rdata, 32'h0000_A5C1);
    access(1'b1, 1'b0, 2'd0, 32'h0);
    chk("t2_rw_new", rdata, 32'h0000_1234);
    tick();
    chk("t2_idle_rdata", rdata, 32'h0);

    // 3: zero suppression with a decimal point on a suppressed digit
    access(1'b0, 1'b1, 2'd0, 32'h0000_0007);
    access(1'b0, 1'b1, 2'd3, 32'h1);
    access(1'b0, 1'b1, 2'd1, 32'h4);
    goto_digit(0);
    chk("t3_d0_seg", 32'(seg_out), 32'h07);
    chk("t3_d0_dig", 32'(dig_en), 32'h1);
    goto_digit(1);
    chk("t3_d1_dig", 32'(dig_en), 32'h0);
    goto_digit(2);
    chk("t3_d2_seg", 32'(seg_out), 32'h80);
    chk("t3_d2_dig", 32'(dig_en), 32'h4);
    goto_digit(3);
    chk("t3_d3_dig", 32'(dig_en), 32'h0);
    access(1'b1, 1'b0, 2'd3, 32'h0);
    chk("t3_read_ctrl", rdata, 32'h1);

    // 4: per-digit enable
    access(1'b0, 1'b1, 2'd0, 32'h0000_A5C1);
    access(1'b0, 1'b1, 2'd3, 32'h0);
    access(1'b0, 1'b1, 2'd1, 32'h0);
    access(1'b0, 1'b1, 2'd2, 32'hFFFF_FFFA);
    bad = 0;
    dark = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (dig_en == 4'b0001 || dig_en == 4'b0100) bad++;
      if (dig_en == 4'b0000) dark++;
    end
    chk("t4_disabled_lit", 32'(bad), 32'h0);
    chk("t4_dark_cycles", 32'(dark), 32'd8);
    access(1'b1, 1'b0, 2'd2, 32'h0);
    chk("t4_read_en", rdata, 32'hA);

    // 5: blink with 2 lit frames then 2 dark frames
    access(1'b0, 1'b1, 2'd2, 32'hF);
    access(1'b0, 1'b1, 2'd3, 32'h2);
    lit = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (dig_en != '0) lit++;
    end
    chk("t5_lit_cycles", 32'(lit), 32'd64);
    guard = 0;
    while (!((((n - 1) / 32) % 2 == 1) && ((n - 1) % 32 == 5)) && guard < 100) begin
      tick();
      guard++;
    end
    chk("t5_find_dark", 32'(guard < 100), 32'h1);
    chk("t5_dark_dig", 32'(dig_en), 32'h0);
    access(1'b0, 1'b1, 2'd3, 32'h0);
    tick();
    chk("t5_release_lit", 32'(dig_en != '0), 32'h1);

    // 6: asynchronous reset mid-frame at digit 2
    access(1'b0, 1'b1, 2'd1, 32'hF);
    guard = 0;
    while (!(((n / SD) % D == 2) && (n % SD == 0)) && guard < 64) begin
      tick();
      guard++;
    end
    access(1'b1, 1'b0, 2'd0, 32'h0);
    chk("t6_pre_rdata", rdata, 32'h0000_A5C1);
    rst = 1'b0;
    #1;
    chk("t6_rst_seg", 32'(seg_out), 32'h0);
    chk("t6_rst_dig", 32'(dig_en), 32'h0);
    chk("t6_rst_rdata", rdata, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_restart_seg", 32'(seg_out), 32'h3F);
    chk("t6_restart_dig", 32'(dig_en), 32'h1);
    repeat (3) tick();
    chk("t6_dwell_dig", 32'(dig_en), 32'h1);
    tick();
    chk("t6_next_dig", 32'(dig_en), 32'h2);
    access(1'b1, 1'b0, 2'd0, 32'h0);
    chk("t6_read_data", rdata, 32'h0);
    access(1'b1, 1'b0, 2'd1, 32'h0);
    chk("t6_read_dp", rdata, 32'h0);
    access(1'b1, 1'b0, 2'd2, 32'h0);
    chk("t6_read_en", rdata, 32'hF);
    access(1'b1, 1'b0, 2'd3, 32'h0);
    chk("t6_read_ctrl", rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
